// File: rtl/jtcontra_gfx_linebuf_rd.sv
// Display-side reader for the 007121 double-buffered line buffer: reads the half not being
// written, one pixel per pxl_cen. Define JTCONTRA_LINEBUF_CLR_EN to erase each location after read.
module jtcontra_gfx_linebuf_rd #(
  parameter int unsigned DW = 9,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic [AW-1:0] hdump,
  input  logic          line,
  input  logic          scr_we,
  input  logic [AW:0]   line_addr,
  input  logic [DW-1:0] line_din,
  input  logic          txt_line,
  output logic [DW-1:0] pxl_out,
  output logic          txt_out,
  output logic          rd_busy
);

  localparam int unsigned Depth = 2 ** (AW + 1);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StClr} st_e;

  st_e           st_q, st_d;
  logic [AW:0]   rd_addr_q, rd_addr_d;
  logic          blank_q, blank_d;
  logic          pend_q, pend_d;
  logic [DW-1:0] pxl_q, pxl_d;
  logic [DW-1:0] q_q;
  logic          rd_en;
  logic          clr_we;
  logic          clr_hit;
  logic          line_l_q;
  logic          txt_l_q;
  logic          txt_q;

  logic [DW-1:0] mem [Depth];

  // Writer owns the address when both ports collide; the erase is dropped.
  assign clr_hit = scr_we && (line_addr == rd_addr_q);

  always_ff @(posedge clk) begin
    if (scr_we) begin
      mem[line_addr] <= line_din;
    end
    if (clr_we && !clr_hit) begin
      mem[rd_addr_q] <= '0;
    end
    if (rd_en) begin
      q_q <= mem[rd_addr_q];
    end
  end

  always_comb begin
    st_d      = st_q;
    rd_addr_d = rd_addr_q;
    blank_d   = blank_q;
    pend_d    = pend_q;
    pxl_d     = pxl_q;
    rd_en     = 1'b0;
    clr_we    = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (pxl_cen || pend_q) begin
          rd_addr_d = {~line, hdump};
          blank_d   = !(LHBL && LVBL);
          pend_d    = 1'b0;
          st_d      = StRd;
        end
      end
      StRd: begin
        rd_en = 1'b1;
        st_d  = StCap;
      end
      StCap: begin
        pxl_d = blank_q ? '0 : q_q;
        st_d  = StClr;
      end
      StClr: begin
`ifdef JTCONTRA_LINEBUF_CLR_EN
        clr_we = !rst;
`else
        clr_we = 1'b0;
`endif
        st_d = StIdle;
      end
      default: st_d = StIdle;
    endcase
    // Only one early pulse is remembered; further ones are spacing violations.
    if (st_q != StIdle && pxl_cen) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= StIdle;
      rd_addr_q <= '0;
      blank_q   <= 1'b0;
      pend_q    <= 1'b0;
      pxl_q     <= '0;
      line_l_q  <= 1'b0;
      txt_l_q   <= 1'b0;
      txt_q     <= 1'b0;
    end else begin
      st_q      <= st_d;
      rd_addr_q <= rd_addr_d;
      blank_q   <= blank_d;
      pend_q    <= pend_d;
      pxl_q     <= pxl_d;
      // txt_l holds the flag of the half just finished, which is now on display.
      if (line != line_l_q) begin
        line_l_q <= line;
        txt_q    <= txt_l_q;
        txt_l_q  <= txt_line;
      end
    end
  end

  assign pxl_out = pxl_q;
  assign txt_out = txt_q;
  assign rd_busy = (st_q != StIdle);

endmodule

// File: tb/tb_jtcontra_gfx_linebuf_rd.sv
// Directed bench for jtcontra_gfx_linebuf_rd; expectations track JTCONTRA_LINEBUF_CLR_EN.
module tb_jtcontra_gfx_linebuf_rd;

  logic       clk = 1'b0;
  logic       rst, pxl_cen, LHBL, LVBL, line, scr_we, txt_line;
  logic [8:0] hdump;
  logic [9:0] line_addr;
  logic [8:0] line_din;
  logic [8:0] pxl_out;
  logic       txt_out, rd_busy;

  int tests = 0;
  int fails = 0;
  int busy_cnt;
  int rise_cnt;
  logic prev_busy;

`ifdef JTCONTRA_LINEBUF_CLR_EN
  localparam bit ClrEn = 1'b1;
`else
  localparam bit ClrEn = 1'b0;
`endif

  jtcontra_gfx_linebuf_rd #(.DW(9), .AW(9)) dut (
    .clk       (clk),
    .rst       (rst),
    .pxl_cen   (pxl_cen),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .hdump     (hdump),
    .line      (line),
    .scr_we    (scr_we),
    .line_addr (line_addr),
    .line_din  (line_din),
    .txt_line  (txt_line),
    .pxl_out   (pxl_out),
    .txt_out   (txt_out),
    .rd_busy   (rd_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [8:0] d);
    scr_we = 1'b1; line_addr = a; line_din = d;
    tick();
    scr_we = 1'b0;
  endtask

  // Full sequence: pulse, RD, CAP, CLR, leaving the FSM idle.
  task automatic rd(input logic [8:0] col);
    hdump = col; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    tick(); tick(); tick();
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; line = 1'b0;
    scr_we = 1'b0; txt_line = 1'b0; hdump = '0; line_addr = '0; line_din = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset pxl_out", pxl_out, 9'h000);
    check("reset txt_out", {8'h0, txt_out}, 9'h000);
    check("reset rd_busy", {8'h0, rd_busy}, 9'h000);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle rd_busy", {8'h0, rd_busy}, 9'h000);
    end

    // Basic read with 3-clk latency
    wr(10'h205, 9'h1A7);
    hdump = 9'd5; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    check("busy in RD", {8'h0, rd_busy}, 9'h001);
    tick();
    check("pxl before latency", pxl_out, 9'h000);
    tick();
    check("pxl after 3 clk", pxl_out, 9'h1A7);
    tick();
    check("idle after CLR", {8'h0, rd_busy}, 9'h000);

    rd(9'd5);
    check("re-read col 5", pxl_out, ClrEn ? 9'h000 : 9'h1A7);

    // Reader sees half 1 while line=0, not half 0
    wr(10'h00C, 9'h1C3);
    wr(10'h20C, 9'h0E1);
    rd(9'd12);
    check("half select", pxl_out, 9'h0E1);

    // Highest column
    wr(10'h3FF, 9'h155);
    rd(9'd511);
    check("col 511", pxl_out, 9'h155);

    // Horizontal and vertical blanking
    wr(10'h20A, 9'h0FF);
    LHBL = 1'b0;
    rd(9'd10);
    check("LHBL blank", pxl_out, 9'h000);
    LHBL = 1'b1;
    rd(9'd10);
    check("after blank", pxl_out, ClrEn ? 9'h000 : 9'h0FF);
    wr(10'h20B, 9'h0AB);
    LVBL = 1'b0;
    rd(9'd11);
    check("LVBL blank", pxl_out, 9'h000);
    LVBL = 1'b1;

    // Two consecutive pulses; pending read uses hdump at service time
    wr(10'h201, 9'h011);
    wr(10'h202, 9'h022);
    hdump = 9'd1; pxl_cen = 1'b1;
    busy_cnt = 0; rise_cnt = 0; prev_busy = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 0) hdump = 9'd2;
      if (i == 1) pxl_cen = 1'b0;
      if (i == 2) check("first of pair", pxl_out, 9'h011);
      if (rd_busy) busy_cnt++;
      if (rd_busy && !prev_busy) rise_cnt++;
      prev_busy = rd_busy;
    end
    check("pair busy cycles", busy_cnt[8:0], 9'd6);
    check("pair reads", rise_cnt[8:0], 9'd2);
    check("pending col", pxl_out, 9'h022);

    // Three pulses in three clk: third one is dropped
    wr(10'h203, 9'h033);
    hdump = 9'd3; pxl_cen = 1'b1;
    busy_cnt = 0; rise_cnt = 0; prev_busy = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 2) pxl_cen = 1'b0;
      if (rd_busy) busy_cnt++;
      if (rd_busy && !prev_busy) rise_cnt++;
      prev_busy = rd_busy;
    end
    check("triple busy cycles", busy_cnt[8:0], 9'd6);
    check("triple reads", rise_cnt[8:0], 9'd2);

    // Text flag follows the displayed line
    txt_line = 1'b1; line = 1'b1;
    tick();
    check("txt toggle 1", {8'h0, txt_out}, 9'h000);
    txt_line = 1'b0; line = 1'b0;
    tick();
    check("txt toggle 2", {8'h0, txt_out}, 9'h001);
    line = 1'b1;
    tick();
    check("txt toggle 3", {8'h0, txt_out}, 9'h000);
    line = 1'b0;
    tick();

    // Reset while in CAP cancels the erase
    wr(10'h207, 9'h0AA);
    hdump = 9'd7; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst in CAP busy", {8'h0, rd_busy}, 9'h000);
    check("rst in CAP pxl", pxl_out, 9'h000);
    tick();
    check("stays idle", {8'h0, rd_busy}, 9'h000);
    rd(9'd7);
    check("no erase on rst", pxl_out, 9'h0AA);
    rd(9'd7);
    check("re-read col 7", pxl_out, ClrEn ? 9'h000 : 9'h0AA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
